step_clock_gen: RTL

//  Debounced single-step clock generator between the board push-button and the pipeline CPU clock input.

---
 rtl/step_clock_gen.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/step_clock_gen.sv
// Debounced single-step clock generator: one clean registered step_clk pulse per accepted button press.
// Optional free-running auto-step mode is enabled by defining STEP_AUTORUN_EN (adds the run port).
module step_clock_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned PULSE_CYCLES    = 5000,
  parameter int unsigned RUN_DIV         = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button,
  input  logic       enable,
`ifdef STEP_AUTORUN_EN
  input  logic       run,
`endif
  output logic       step_clk,
  output logic       step_pulse,
  output logic [7:0] ticks,
  output logic       busy
);

  localparam int unsigned CNT_MAX = (DEBOUNCE_CYCLES > PULSE_CYCLES) ? DEBOUNCE_CYCLES : PULSE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    HIGH     = 3'd2,
    WAIT_REL = 3'd3,
    REL_DB   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             auto_src, auto_nxt;
  logic             enter_high;
  logic             sync1, btn_s;

`ifdef STEP_AUTORUN_EN
  localparam int unsigned DIV_W = $clog2(RUN_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  logic [DIV_W-1:0] div, div_nxt;
`endif

  // Two-flop synchronizer for the raw button
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= button;
      btn_s <= sync1;
    end
  end

  // Next-state logic; the same counter serves both debounce windows and the pulse width
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    auto_nxt   = auto_src;
    enter_high = 1'b0;
`ifdef STEP_AUTORUN_EN
    div_nxt    = '0;
`endif
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = PRESS_DB;
          cnt_nxt   = '0;
        end
`ifdef STEP_AUTORUN_EN
        else if (run && enable) begin
          if (div == DIV_LAST) begin
            state_nxt  = HIGH;
            cnt_nxt    = '0;
            auto_nxt   = 1'b1;
            enter_high = 1'b1;
          end else begin
            div_nxt = div + DIV_W'(1);
          end
        end
`endif
      end
      PRESS_DB: begin
        if (!btn_s) begin
          state_nxt = IDLE;
        end else if (cnt == DB_LAST) begin
          cnt_nxt = '0;
          if (enable) begin
            state_nxt  = HIGH;
            auto_nxt   = 1'b0;
            enter_high = 1'b1;
          end else begin
            state_nxt = WAIT_REL;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HIGH: begin
        if (cnt == PULSE_LAST) begin
          cnt_nxt   = '0;
          state_nxt = auto_src ? IDLE : WAIT_REL;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WAIT_REL: begin
        if (!btn_s) begin
          state_nxt = REL_DB;
          cnt_nxt   = '0;
        end
      end
      REL_DB: begin
        if (btn_s) begin
          state_nxt = WAIT_REL;
        end else if (cnt == DB_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = WAIT_REL;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State register; outputs are flops driven from the next state so they never glitch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= WAIT_REL;
      cnt        <= '0;
      auto_src   <= 1'b0;
      step_clk   <= 1'b0;
      step_pulse <= 1'b0;
      ticks      <= 8'd0;
      busy       <= 1'b1;
`ifdef STEP_AUTORUN_EN
      div        <= '0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      auto_src   <= auto_nxt;
      step_clk   <= (state_nxt == HIGH);
      step_pulse <= enter_high;
      ticks      <= ticks + 8'(enter_high);
      busy       <= (state_nxt != IDLE);
`ifdef STEP_AUTORUN_EN
      div        <= div_nxt;
`endif
    end
  end

endmodule
